mem_rmw_ctrl: RTL and testbench
===============================

MEM_RMW_CTRL -- requirements
Module: mem_rmw_ctrl

Interface
REQ-001 SHALL have one clock and a synchronous, active-low reset; all state changes on rising edge of clk.
REQ-002 clk  in  1  system clock.
REQ-003 rst_n  in  1  synchronous active-low reset.
REQ-004 req  in  1  CPU access request; sampled only in IDLE.
REQ-005 req_we  in  1  1 = store, 0 = load.
REQ-006 req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-007 req_unsigned  in  1  load zero-extend (1) / sign-extend (0).
REQ-008 req_addr  in  12  byte address within 4 KiB.
REQ-009 req_wdata  in  32  store data, right-justified.
REQ-010 busy  out  1  high in RD and WR states.
REQ-011 done  out  1  one-cycle completion pulse.
REQ-012 misalign  out  1  valid with done; access rejected.
REQ-013 rdata  out  32  extended load result; holds until next successful load.
REQ-014 dm_ad  out  10  word address to data memory (latched req_addr[11:2]).
REQ-015 dm_din  out  32  merged write word.
REQ-016 dm_we  out  1  data memory write enable.
REQ-017 dm_dout  in  32  combinational read word from data memory.

Function
REQ-018 FSM states: IDLE, RD, WR, DONE; busy = state in {RD, WR}; done = state is DONE.
REQ-019 IDLE and req=1: latch we/size/unsigned/addr/wdata; illegal if size=11, half with addr[0]=1, or word with addr[1:0]!=0.
REQ-020 Illegal: next state DONE, misalign=1 in DONE, no dm_we, rdata unchanged.
REQ-021 Legal load or sub-word store: IDLE -> RD; legal word store: IDLE -> WR (no read).
REQ-022 RD, load: register extracted dm_dout into rdata at end of RD, -> DONE (load latency 2 cycles req-to-done).
REQ-023 RD, sub-word store: register dm_dout with target lane(s) replaced by req_wdata low bits into dm_din, -> WR.
REQ-024 Word store: dm_din = req_wdata latched in IDLE.
REQ-025 WR: dm_we = 1 for exactly one cycle, -> DONE (sub-word store latency 3, word store 2).
REQ-026 DONE: -> IDLE unconditionally; req during RD/WR/DONE ignored, not queued.
REQ-027 Little-endian lanes: byte at addr[1:0]=k occupies bits 8k+7:8k; halfword at addr[1]=h occupies bits 16h+15:16h.
REQ-028 Load extension: byte/half sign- or zero-extended to 32 per req_unsigned; word loads ignore req_unsigned.
REQ-029 dm_ad, dm_din hold latched values outside active states; misalign=0 except in DONE after illegal request.
REQ-030 Back-to-back: new req accepted in IDLE cycle immediately after DONE; throughput 1 access per 3-4 cycles.

Reset
REQ-031 rst_n=0 at an edge: state IDLE, rdata=0, dm_ad=0, dm_din=0, latched fields 0.
REQ-032 dm_we SHALL be (state==WR) AND rst_n, so reset asserted in WR suppresses the write at that edge.
REQ-033 Reset mid-RD/WR aborts the access; no done pulse is issued for it.

Structure
REQ-034 Shared package mem_ctrl_pkg SHALL hold size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and FSM state encoding.
REQ-035 Lane extract/merge logic SHALL be a combinational sub-module dm_lane_align (inputs word, addr[1:0], size, unsigned, wdata; outputs load value, merged word).

Verification
REQ-036 Bench pairs block with the team's 4 KiB word data memory model, preloaded to 0.
REQ-037 Word store 0xDEADBEEF @0x010, then word load @0x010 -> rdata=0xDEADBEEF, store done 2 cycles and load done 2 cycles after req.
REQ-038 Byte store 0x80 @0x013 over word 0x11223344 -> mem word 0x80223344; signed byte load @0x013 -> 0xFFFFFF80; unsigned -> 0x00000080.
REQ-039 Half store 0xBEEF @0x022 over 0 -> word 0xBEEF0000; signed half load @0x022 -> 0xFFFFBEEF; done 3 cycles after store req.
REQ-040 Word load @0x006 and size=11 request -> done with misalign=1 one cycle after req, dm_we never high, rdata unchanged.
REQ-041 rst_n=0 during WR of byte store @0x004 -> memory word unchanged, no done, state IDLE, rdata=0.
REQ-042 req held high continuously -> accesses accepted only in IDLE, exactly one done per accepted request.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the read-modify-write data memory controller:
// access size encodings, FSM state encoding and the alignment rule.
package mem_ctrl_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRd   = 2'd1,
        StWr   = 2'd2,
        StDone = 2'd3
    } state_e;

    // True when the size code is reserved or the address is not naturally aligned.
    function automatic logic access_illegal(input logic [1:0] size, input logic [1:0] lane);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = lane[0];
            SZ_WORD: bad = (lane != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dm_lane_align.sv
// Combinational little-endian lane logic: extracts and extends a load value
// from a memory word, and merges store data into the addressed lane(s).
module dm_lane_align
    import mem_ctrl_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    output logic [31:0] load_val,
    output logic [31:0] merged
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[{addr, 3'b000} +: 8];
        half_sel = word[{addr[1], 4'b0000} +: 16];
        load_val = word;
        merged   = word;
        case (size)
            SZ_BYTE: begin
                load_val = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
                merged[{addr, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_HALF: begin
                load_val = {{16{~is_unsigned & half_sel[15]}}, half_sel};
                merged[{addr[1], 4'b0000} +: 16] = wdata[15:0];
            end
            SZ_WORD: begin
                load_val = word;
                merged   = wdata;
            end
            default: begin
                load_val = word;
                merged   = word;
            end
        endcase
    end

endmodule

// File: rtl/mem_rmw_ctrl.sv
// CPU-side load/store controller for a word-wide data memory; sub-word stores
// are done as read-modify-write, word stores skip the read.
module mem_rmw_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [11:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        busy,
    output logic        done,
    output logic        misalign,
    output logic [31:0] rdata,
    output logic [9:0]  dm_ad,
    output logic [31:0] dm_din,
    output logic        dm_we,
    input  logic [31:0] dm_dout
);

    state_e      state;
    logic        lat_we;
    logic [1:0]  lat_size;
    logic        lat_uns;
    logic [1:0]  lat_lane;
    logic [31:0] lat_wdata;
    logic [31:0] load_val;
    logic [31:0] merged;

    dm_lane_align u_align (
        .word        (dm_dout),
        .addr        (lat_lane),
        .size        (lat_size),
        .is_unsigned (lat_uns),
        .wdata       (lat_wdata),
        .load_val    (load_val),
        .merged      (merged)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= StIdle;
            lat_we    <= 1'b0;
            lat_size  <= 2'b00;
            lat_uns   <= 1'b0;
            lat_lane  <= 2'b00;
            lat_wdata <= 32'h0;
            rdata     <= 32'h0;
            dm_ad     <= 10'h0;
            dm_din    <= 32'h0;
            misalign  <= 1'b0;
        end else begin
            misalign <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (req) begin
                        lat_we    <= req_we;
                        lat_size  <= req_size;
                        lat_uns   <= req_unsigned;
                        lat_lane  <= req_addr[1:0];
                        lat_wdata <= req_wdata;
                        dm_ad     <= req_addr[11:2];
                        if (access_illegal(req_size, req_addr[1:0])) begin
                            misalign <= 1'b1;
                            state    <= StDone;
                        end else if (req_we && req_size == SZ_WORD) begin
                            dm_din <= req_wdata;
                            state  <= StWr;
                        end else begin
                            state <= StRd;
                        end
                    end
                end
                StRd: begin
                    if (lat_we) begin
                        dm_din <= merged;
                        state  <= StWr;
                    end else begin
                        rdata <= load_val;
                        state <= StDone;
                    end
                end
                StWr:   state <= StDone;
                StDone: state <= StIdle;
                default: state <= StIdle;
            endcase
        end
    end

    assign busy  = (state == StRd) || (state == StWr);
    assign done  = (state == StDone);
    // Gated by reset so an in-flight write is dropped at the reset edge.
    assign dm_we = (state == StWr) && rst_n;

endmodule

// File: tb/tb_mem_rmw_ctrl.sv
// Self-checking bench: directed and random accesses against a word-array
// reference model of memory and the last load result.
module tb_mem_rmw_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [11:0] req_addr;
    logic [31:0] req_wdata;
    logic        busy;
    logic        done;
    logic        misalign;
    logic [31:0] rdata;
    logic [9:0]  dm_ad;
    logic [31:0] dm_din;
    logic        dm_we;
    logic [31:0] dm_dout;

    logic [31:0] mem [0:1023] = '{default: 32'h0};
    logic [31:0] ref_mem [0:1023];
    logic [31:0] ref_rdata;
    int          errors = 0;
    int          checks = 0;
    int          we_count = 0;

    always #5 clk = ~clk;

    mem_rmw_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .busy         (busy),
        .done         (done),
        .misalign     (misalign),
        .rdata        (rdata),
        .dm_ad        (dm_ad),
        .dm_din       (dm_din),
        .dm_we        (dm_we),
        .dm_dout      (dm_dout)
    );

    assign dm_dout = mem[dm_ad];

    always @(posedge clk) begin
        if (dm_we) begin
            mem[dm_ad] <= dm_din;
            we_count   <= we_count + 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic illegal(input logic [1:0] size, input logic [11:0] a);
        return (size == 2'd3) || (size == 2'd1 && (a % 2) != 0) || (size == 2'd2 && (a % 4) != 0);
    endfunction

    task automatic access(input logic we, input logic [1:0] size, input logic uns,
                          input logic [11:0] addr, input logic [31:0] wdata, input string tag);
        int          lat_exp;
        int          c;
        int          we0;
        int          sh;
        logic        bad;
        logic [31:0] w;
        logic [31:0] v;
        logic [31:0] mask;
        bad  = illegal(size, addr);
        w    = ref_mem[addr / 4];
        sh   = 8 * (addr % 4);
        mask = (size == 2'd0) ? 32'hFF : (size == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
        if (bad)                    lat_exp = 1;
        else if (we && size == 2'd2) lat_exp = 2;
        else if (we)                lat_exp = 3;
        else                        lat_exp = 2;
        if (!bad && we) begin
            ref_mem[addr / 4] = (w & ~(mask << sh)) | ((wdata & mask) << sh);
        end else if (!bad) begin
            v = (w >> sh) & mask;
            if (!uns && size == 2'd0 && v[7])  v = v | 32'hFFFF_FF00;
            if (!uns && size == 2'd1 && v[15]) v = v | 32'hFFFF_0000;
            ref_rdata = v;
        end
        we0          = we_count;
        req          = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        step();
        req = 1'b0;
        c   = 1;
        while (!done && c < 8) begin
            step();
            c++;
        end
        check({tag, ":latency"}, 32'(c), 32'(lat_exp));
        check({tag, ":done"}, 32'(done), 32'd1);
        check({tag, ":busy"}, 32'(busy), 32'd0);
        check({tag, ":misalign"}, 32'(misalign), 32'(bad));
        check({tag, ":rdata"}, rdata, ref_rdata);
        check({tag, ":writes"}, 32'(we_count - we0), 32'(!bad && we));
        check({tag, ":memword"}, mem[addr / 4], ref_mem[addr / 4]);
        step();
        check({tag, ":done_clr"}, 32'({done, misalign}), 32'd0);
    endtask

    initial begin
        int ndone;
        int last;
        int we0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
        ref_rdata    = 32'h0;
        rst_n        = 1'b0;
        req          = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = 12'h0;
        req_wdata    = 32'h0;
        step();
        step();
        check("reset:busy", 32'(busy), 32'd0);
        check("reset:done", 32'(done), 32'd0);
        check("reset:misalign", 32'(misalign), 32'd0);
        check("reset:dm_we", 32'(dm_we), 32'd0);
        check("reset:rdata", rdata, 32'h0);
        check("reset:dm_ad", 32'(dm_ad), 32'h0);
        check("reset:dm_din", dm_din, 32'h0);
        rst_n = 1'b1;
        step();

        access(1'b1, 2'd2, 1'b0, 12'h010, 32'hDEAD_BEEF, "wstore");
        check("wstore:const", mem[4], 32'hDEAD_BEEF);
        access(1'b0, 2'd2, 1'b0, 12'h010, 32'h0, "wload");
        check("wload:const", rdata, 32'hDEAD_BEEF);

        access(1'b1, 2'd2, 1'b0, 12'h010, 32'h1122_3344, "pre");
        access(1'b1, 2'd0, 1'b0, 12'h013, 32'h0000_0080, "bstore");
        check("bstore:const", mem[4], 32'h8022_3344);
        access(1'b0, 2'd0, 1'b0, 12'h013, 32'h0, "bload_s");
        check("bload_s:const", rdata, 32'hFFFF_FF80);
        access(1'b0, 2'd0, 1'b1, 12'h013, 32'h0, "bload_u");
        check("bload_u:const", rdata, 32'h0000_0080);

        access(1'b1, 2'd1, 1'b0, 12'h022, 32'h0000_BEEF, "hstore");
        check("hstore:const", mem[8], 32'hBEEF_0000);
        access(1'b0, 2'd1, 1'b0, 12'h022, 32'h0, "hload");
        check("hload:const", rdata, 32'hFFFF_BEEF);

        access(1'b0, 2'd2, 1'b0, 12'h006, 32'h0, "misal_w");
        access(1'b1, 2'd3, 1'b0, 12'h040, 32'h1234_5678, "illegal_sz");
        check("illegal_sz:rdata", rdata, 32'hFFFF_BEEF);

        for (int i = 0; i < 40; i++) begin
            access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   12'($urandom_range(0, 255)), $urandom, "rand");
        end

        // Reset asserted while a byte store sits in WR.
        access(1'b1, 2'd2, 1'b0, 12'h004, 32'hCAFE_F00D, "rst_pre");
        req       = 1'b1;
        req_we    = 1'b1;
        req_size  = 2'd0;
        req_addr  = 12'h004;
        req_wdata = 32'h0000_0055;
        step();
        req = 1'b0;
        step();
        check("rst:wr_we", 32'(dm_we), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst:we_gated", 32'(dm_we), 32'd0);
        we0 = we_count;
        step();
        check("rst:no_write", 32'(we_count - we0), 32'd0);
        check("rst:memword", mem[1], 32'hCAFE_F00D);
        rst_n     = 1'b1;
        ref_rdata = 32'h0;
        for (int i = 0; i < 4; i++) begin
            check("rst:no_done", 32'({done, busy}), 32'd0);
            step();
        end
        check("rst:rdata", rdata, ref_rdata);

        // Request held high: accepted only from IDLE, one done per access.
        req      = 1'b1;
        req_we   = 1'b0;
        req_size = 2'd2;
        req_addr = 12'h010;
        ndone    = 0;
        last     = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (done) begin
                ndone++;
                last = i;
                check("held:rdata", rdata, ref_mem[4]);
            end
        end
        req = 1'b0;
        check("held:count", 32'(ndone), 32'd7);
        check("held:last", 32'(last), 32'd20);
        step();
        check("held:idle", 32'({busy, done}), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
